// File: rtl/swg_dilated.sv
// swg_dilated: dilated/strided sliding-window generator over a circular line buffer.
// Define SWG_PAD_EN to enable the zero border (PAD_W/PAD_H); otherwise padding is 0.
module swg_dilated #(
  parameter int    SIMD      = 1,
  parameter int    PRECISION = 8,
  parameter int    IFM_CH    = 2,
  parameter int    IFM_W     = 8,
  parameter int    IFM_H     = 8,
  parameter int    K_W       = 3,
  parameter int    K_H       = 3,
  parameter int    STRIDE_W  = 1,
  parameter int    STRIDE_H  = 1,
  parameter int    DIL_W     = 1,
  parameter int    DIL_H     = 1,
  parameter int    PAD_W     = 0,
  parameter int    PAD_H     = 0,
  parameter string RAM_STYLE = "auto"
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [SIMD*PRECISION-1:0]   s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [SIMD*PRECISION-1:0]   m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready
);

`ifdef SWG_PAD_EN
  localparam int PW = PAD_W;
  localparam int PH = PAD_H;
`else
  // border compiled out: pad parameters are ignored
  localparam int PW = PAD_W * 0;
  localparam int PH = PAD_H * 0;
`endif

  localparam int DW    = SIMD * PRECISION;
  localparam int CF    = IFM_CH / SIMD;
  localparam int KE_W  = DIL_W * (K_W - 1) + 1;
  localparam int KE_H  = DIL_H * (K_H - 1) + 1;
  localparam int OFM_W = (IFM_W + 2 * PW - KE_W) / STRIDE_W + 1;
  localparam int OFM_H = (IFM_H + 2 * PH - KE_H) / STRIDE_H + 1;
  localparam int ROWW  = IFM_W * CF;
  localparam int DEPTH = KE_H * ROWW;
  localparam int N_IN  = IFM_H * ROWW;
  localparam int N_OUT = OFM_H * OFM_W * K_H * K_W * CF;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(N_IN + 1);
  localparam int OW    = $clog2(N_OUT + 1);

  (* ram_style = RAM_STYLE *)
  logic [DW-1:0] r_mem [DEPTH];

  logic [15:0]   r_oy, r_ox, r_ky, r_kx, r_c;
  logic [CW-1:0] r_wr;
  logic [AW-1:0] r_wp;
  logic [OW-1:0] r_out;
  logic          r_done;
  logic [1:0]    r_cnt;
  logic [DW-1:0] r_q0, r_q1;

  int            w_y0, w_x0, w_iy, w_ix;
  int            w_top, w_ymax, w_xmax, w_need;
  logic          w_pad, w_avail, w_issue;
  logic          w_pop, w_wr, w_last, w_in_rdy;
  logic [AW-1:0] w_raddr;
  logic [DW-1:0] w_rdata;

  always_comb begin
    w_y0 = int'(r_oy) * STRIDE_H - PH;
    w_x0 = int'(r_ox) * STRIDE_W - PW;
    w_iy = w_y0 + int'(r_ky) * DIL_H;
    w_ix = w_x0 + int'(r_kx) * DIL_W;
    w_top = (w_y0 < 0) ? 0 : w_y0;
    w_ymax = w_y0 + KE_H - 1;
    if (w_ymax > IFM_H - 1) w_ymax = IFM_H - 1;
    if (w_ymax < 0) w_ymax = 0;
    w_xmax = w_x0 + KE_W - 1;
    if (w_xmax > IFM_W - 1) w_xmax = IFM_W - 1;
    if (w_xmax < 0) w_xmax = 0;
    // window may be read once its last in-image word is present
    w_need = (w_ymax * IFM_W + w_xmax) * CF + CF - 1;
    w_avail = int'(r_wr) > w_need;
`ifdef SWG_PAD_EN
    w_pad = (w_iy < 0) || (w_iy >= IFM_H) ||
            (w_ix < 0) || (w_ix >= IFM_W);
`else
    w_pad = 1'b0;
`endif
    w_raddr = AW'(((w_iy % KE_H) * IFM_W + w_ix) * CF + int'(r_c));
    w_in_rdy = (int'(r_wr) - w_top * ROWW < DEPTH) &&
               (int'(r_wr) < N_IN);
    w_pop = m_axis_tvalid & m_axis_tready;
    w_issue = !r_done && (w_pad || w_avail) &&
              (int'(r_cnt) - int'(w_pop) < 2);
    w_last = w_pop && (int'(r_out) == N_OUT - 1);
    w_wr = s_axis_tvalid & s_axis_tready;
  end

  assign s_axis_tready = aresetn & w_in_rdy;
  assign m_axis_tvalid = (r_cnt != 2'd0);
  assign m_axis_tdata  = r_q0;
  assign w_rdata       = w_pad ? '0 : r_mem[w_raddr];

  always_ff @(posedge aclk) begin
    if (w_wr) r_mem[r_wp] <= s_axis_tdata;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr   <= '0;
      r_wp   <= '0;
      r_out  <= '0;
      r_done <= 1'b0;
      r_oy   <= '0;
      r_ox   <= '0;
      r_ky   <= '0;
      r_kx   <= '0;
      r_c    <= '0;
    end else if (w_last) begin
      r_wr   <= '0;
      r_wp   <= '0;
      r_out  <= '0;
      r_done <= 1'b0;
      r_oy   <= '0;
      r_ox   <= '0;
      r_ky   <= '0;
      r_kx   <= '0;
      r_c    <= '0;
    end else begin
      if (w_wr) begin
        r_wr <= r_wr + 1'b1;
        r_wp <= (r_wp == AW'(DEPTH - 1)) ? '0 : r_wp + 1'b1;
      end
      if (w_pop) r_out <= r_out + 1'b1;
      if (w_issue) begin
        if (r_c == 16'(CF - 1)) begin
          r_c <= '0;
          if (r_kx == 16'(K_W - 1)) begin
            r_kx <= '0;
            if (r_ky == 16'(K_H - 1)) begin
              r_ky <= '0;
              if (r_ox == 16'(OFM_W - 1)) begin
                r_ox <= '0;
                if (r_oy == 16'(OFM_H - 1)) begin
                  r_oy   <= '0;
                  r_done <= 1'b1;
                end else r_oy <= r_oy + 1'b1;
              end else r_ox <= r_ox + 1'b1;
            end else r_ky <= r_ky + 1'b1;
          end else r_kx <= r_kx + 1'b1;
        end else r_c <= r_c + 1'b1;
      end
    end
  end

  // two-entry output skid, head in r_q0
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_cnt <= '0;
      r_q0  <= '0;
      r_q1  <= '0;
    end else begin
      case ({w_issue, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_q0 <= w_rdata;
          else               r_q1 <= w_rdata;
          r_cnt <= r_cnt + 1'b1;
        end
        2'b01: begin
          r_q0  <= r_q1;
          r_cnt <= r_cnt - 1'b1;
        end
        2'b11: begin
          if (r_cnt == 2'd1) r_q0 <= w_rdata;
          else begin
            r_q0 <= r_q1;
            r_q1 <= w_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
